// File: rtl/mgr_stack_bus_ds_tx.sv
// Manager-side downstream stack-bus transmitter: store-and-forward packet FIFO
// with input framing policing and a registered stack-bus output stage.
module mgr_stack_bus_ds_tx #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int PKT_MAX_LEN = 16,
  parameter int CNT_W       = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              mgr_ds_valid,
  input  logic [1:0]        mgr_ds_cntl,
  input  logic [DATA_W-1:0] mgr_ds_data,
  output logic              mgr_ds_ready,
  output logic              sb_ds_valid,
  output logic [1:0]        sb_ds_cntl,
  output logic [DATA_W-1:0] sb_ds_data,
  input  logic              sb_ds_ready,
  output logic [CNT_W-1:0]  pkts_buffered,
  output logic              err_pkt_too_long,
  output logic              err_protocol
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(PKT_MAX_LEN+1);

  localparam logic [1:0] C_MOP = 2'b00;
  localparam logic [1:0] C_SOP = 2'b01;
  localparam logic [1:0] C_EOP = 2'b10;
  localparam logic [1:0] C_SOM = 2'b11;

  typedef enum logic [1:0] {IN_IDLE, IN_PKT, IN_DROP} in_st_t;
  typedef enum logic       {OUT_IDLE, OUT_SEND}       out_st_t;

  logic [DATA_W+1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d, pkts_q, pkts_d;
  in_st_t            in_st_q, in_st_d;
  out_st_t           out_st_q, out_st_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic              err_long_q, err_long_d, err_proto_q, err_proto_d;
  logic              sb_valid_q, sb_valid_d;
  logic [1:0]        sb_cntl_q, sb_cntl_d;
  logic [DATA_W-1:0] sb_data_q, sb_data_d;

  logic              fifo_full, fifo_empty, in_ready, acc;
  logic              wr_en, rd_en, pkt_done, pkt_pop, load_en;
  logic [1:0]        wr_cntl, head_cntl;
  logic [DATA_W-1:0] head_data;
  logic [WW-1:0]     word_cnt_inc;

  assign fifo_full    = (occ_q == CNT_W'(DEPTH));
  assign fifo_empty   = (occ_q == '0);
  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign in_ready     = !reset_poweron && ((in_st_q == IN_DROP) || !fifo_full);
  assign acc          = mgr_ds_valid && in_ready;
  assign word_cnt_inc = word_cnt_q + WW'(1);
  assign head_cntl    = mem_q[rd_ptr_q][DATA_W+1:DATA_W];
  assign head_data    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign load_en      = !sb_valid_q || sb_ds_ready;

  // Input framing FSM
  always_comb begin
    in_st_d     = in_st_q;
    word_cnt_d  = word_cnt_q;
    err_long_d  = err_long_q;
    err_proto_d = err_proto_q;
    wr_en       = 1'b0;
    wr_cntl     = mgr_ds_cntl;
    pkt_done    = 1'b0;
    if (acc) begin
      case (in_st_q)
        IN_IDLE: begin
          case (mgr_ds_cntl)
            C_SOM: begin
              wr_en    = 1'b1;
              pkt_done = 1'b1;
            end
            C_SOP: begin
              wr_en      = 1'b1;
              word_cnt_d = WW'(1);
              in_st_d    = IN_PKT;
            end
            default: err_proto_d = 1'b1;
          endcase
        end
        IN_PKT: begin
          wr_en      = 1'b1;
          word_cnt_d = word_cnt_inc;
          if (mgr_ds_cntl == C_EOP) begin
            pkt_done = 1'b1;
            in_st_d  = IN_IDLE;
          end else begin
            if (mgr_ds_cntl == C_SOP || mgr_ds_cntl == C_SOM) begin
              err_proto_d = 1'b1;
              wr_cntl     = C_MOP;
            end
            // Truncate at the length limit so the stored packet is always complete.
            if (word_cnt_inc == WW'(PKT_MAX_LEN)) begin
              wr_cntl    = C_EOP;
              pkt_done   = 1'b1;
              err_long_d = 1'b1;
              in_st_d    = IN_DROP;
            end
          end
        end
        IN_DROP: begin
          if (mgr_ds_cntl == C_EOP) in_st_d = IN_IDLE;
        end
        default: in_st_d = IN_IDLE;
      endcase
    end
  end

  // Output FSM: only starts a packet once it is wholly resident in the FIFO
  always_comb begin
    out_st_d   = out_st_q;
    sb_valid_d = sb_valid_q;
    sb_cntl_d  = sb_cntl_q;
    sb_data_d  = sb_data_q;
    rd_en      = 1'b0;
    pkt_pop    = 1'b0;
    if (load_en) begin
      sb_valid_d = 1'b0;
      case (out_st_q)
        OUT_IDLE: begin
          if (pkts_q != '0) begin
            rd_en      = 1'b1;
            sb_valid_d = 1'b1;
            sb_cntl_d  = head_cntl;
            sb_data_d  = head_data;
            if (head_cntl == C_SOP) out_st_d = OUT_SEND;
            else                    pkt_pop  = 1'b1;
          end
        end
        OUT_SEND: begin
          if (!fifo_empty) begin
            rd_en      = 1'b1;
            sb_valid_d = 1'b1;
            sb_cntl_d  = head_cntl;
            sb_data_d  = head_data;
            if (head_cntl == C_EOP) begin
              pkt_pop  = 1'b1;
              out_st_d = OUT_IDLE;
            end
          end
        end
        default: out_st_d = OUT_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    case ({pkt_done, pkt_pop})
      2'b10:   pkts_d = pkts_q + CNT_W'(1);
      2'b01:   pkts_d = pkts_q - CNT_W'(1);
      default: pkts_d = pkts_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_cntl, mgr_ds_data};
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      pkts_q      <= '0;
      in_st_q     <= IN_IDLE;
      out_st_q    <= OUT_IDLE;
      word_cnt_q  <= '0;
      err_long_q  <= 1'b0;
      err_proto_q <= 1'b0;
      sb_valid_q  <= 1'b0;
      sb_cntl_q   <= '0;
      sb_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      pkts_q      <= pkts_d;
      in_st_q     <= in_st_d;
      out_st_q    <= out_st_d;
      word_cnt_q  <= word_cnt_d;
      err_long_q  <= err_long_d;
      err_proto_q <= err_proto_d;
      sb_valid_q  <= sb_valid_d;
      sb_cntl_q   <= sb_cntl_d;
      sb_data_q   <= sb_data_d;
    end
  end

  assign mgr_ds_ready     = in_ready;
  assign sb_ds_valid      = sb_valid_q;
  assign sb_ds_cntl       = sb_cntl_q;
  assign sb_ds_data       = sb_data_q;
  assign pkts_buffered    = pkts_q;
  assign err_pkt_too_long = err_long_q;
  assign err_protocol     = err_proto_q;

endmodule

// File: tb/tb_mgr_stack_bus_ds_tx.sv
// Directed bench for mgr_stack_bus_ds_tx: framing, latency, backpressure,
// truncation, protocol errors and mid-packet reset.
module tb_mgr_stack_bus_ds_tx;

  localparam logic [1:0] MOP = 2'b00, SOP = 2'b01, EOP = 2'b10, SOM = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        mgr_ds_valid;
  logic [1:0]  mgr_ds_cntl;
  logic [31:0] mgr_ds_data;
  logic        mgr_ds_ready;
  logic        sb_ds_valid;
  logic [1:0]  sb_ds_cntl;
  logic [31:0] sb_ds_data;
  logic        sb_ds_ready;
  logic [4:0]  pkts_buffered;
  logic        err_pkt_too_long;
  logic        err_protocol;

  mgr_stack_bus_ds_tx dut (
    .clk(clk), .reset_poweron(rst),
    .mgr_ds_valid(mgr_ds_valid), .mgr_ds_cntl(mgr_ds_cntl), .mgr_ds_data(mgr_ds_data),
    .mgr_ds_ready(mgr_ds_ready),
    .sb_ds_valid(sb_ds_valid), .sb_ds_cntl(sb_ds_cntl), .sb_ds_data(sb_ds_data),
    .sb_ds_ready(sb_ds_ready),
    .pkts_buffered(pkts_buffered),
    .err_pkt_too_long(err_pkt_too_long), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] d;
    int          t;
  } rx_t;
  rx_t rx_q[$];

  always @(negedge clk) begin
    rx_t r;
    if (sb_ds_valid && sb_ds_ready && !rst) begin
      r.c = sb_ds_cntl; r.d = sb_ds_data; r.t = cyc;
      rx_q.push_back(r);
    end
  end

  int total = 0, bad = 0;
  int acc_cyc;

  task automatic send_word(input logic [1:0] c, input logic [31:0] d);
    bit ok = 0;
    mgr_ds_valid = 1'b1; mgr_ds_cntl = c; mgr_ds_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mgr_ds_ready) begin ok = 1; acc_cyc = cyc; end
    end
    @(posedge clk) #1;
    mgr_ds_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_word_timeout data=%h never accepted", d);
    end
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 300 && rx_q.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != n) begin
      bad++;
      $display("FAIL rx_count got=%0d want=%0d", rx_q.size(), n);
    end
  endtask

  task automatic chk_word(input int i, input logic [1:0] c, input logic [31:0] d);
    total++;
    if (i >= rx_q.size()) begin
      bad++;
      $display("FAIL word%0d missing want=%b/%h", i, c, d);
    end else if (rx_q[i].c !== c || rx_q[i].d !== d) begin
      bad++;
      $display("FAIL word%0d got=%b/%h want=%b/%h", i, rx_q[i].c, rx_q[i].d, c, d);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mgr_ds_valid = 0; mgr_ds_cntl = 0; mgr_ds_data = 0; sb_ds_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sb_ds_valid, sb_ds_cntl, sb_ds_data, pkts_buffered, err_pkt_too_long, err_protocol, mgr_ds_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs v=%b c=%b d=%h p=%0d el=%b ep=%b r=%b want all 0",
               sb_ds_valid, sb_ds_cntl, sb_ds_data, pkts_buffered, err_pkt_too_long, err_protocol, mgr_ds_ready);
    end
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mgr_ds_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", mgr_ds_ready); end
    @(posedge clk) #1;
  endtask

  task automatic test_basic;
    int a;
    logic [1:0] ec[4] = '{SOP, MOP, MOP, EOP};
    rx_q.delete(); sb_ds_ready = 1'b1;
    send_word(SOP, 32'h11); send_word(MOP, 32'h22); send_word(MOP, 32'h33); send_word(EOP, 32'h44);
    a = acc_cyc;
    @(negedge clk);
    total++;
    if (pkts_buffered !== 5'd1) begin bad++; $display("FAIL basic_pkts1 got=%0d want=1", pkts_buffered); end
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      chk_word(i, ec[i], 32'h11 * (i + 1));
      total++;
      if (i < rx_q.size() && rx_q[i].t != a + 2 + i) begin
        bad++; $display("FAIL basic_timing word%0d got=%0d want=%0d", i, rx_q[i].t, a + 2 + i);
      end
    end
    total++;
    if (pkts_buffered !== 5'd0) begin bad++; $display("FAIL basic_pkts0 got=%0d want=0", pkts_buffered); end
  endtask

  task automatic test_back_to_back;
    int a;
    rx_q.delete();
    send_word(SOM, 32'hA5); a = acc_cyc;
    send_word(SOM, 32'h5A);
    wait_rx(2);
    chk_word(0, SOM, 32'hA5);
    chk_word(1, SOM, 32'h5A);
    total++;
    if (rx_q.size() == 2 && (rx_q[0].t != a + 2 || rx_q[1].t != a + 3)) begin
      bad++; $display("FAIL b2b_timing got=%0d,%0d want=%0d,%0d", rx_q[0].t, rx_q[1].t, a + 2, a + 3);
    end
    total++;
    if (err_protocol !== 1'b0) begin bad++; $display("FAIL b2b_err_protocol got=%b want=0", err_protocol); end
  endtask

  task automatic test_full_stall;
    logic [1:0]  ec[20];
    logic [31:0] ed[20];
    int idx = 0, unstable = 0;
    bit rdy;
    for (int i = 0; i < 20; i++) begin
      ec[i] = (i % 4 == 0) ? SOP : (i % 4 == 3) ? EOP : MOP;
      ed[i] = 32'h100 + i;
    end
    rx_q.delete(); sb_ds_ready = 1'b0;
    mgr_ds_valid = 1'b1; mgr_ds_cntl = ec[0]; mgr_ds_data = ed[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb_ds_valid && (sb_ds_data !== 32'h100 || sb_ds_cntl !== SOP)) unstable++;
      rdy = mgr_ds_ready;
      @(posedge clk) #1;
      if (rdy && idx < 19) begin idx++; mgr_ds_cntl = ec[idx]; mgr_ds_data = ed[idx]; end
    end
    @(negedge clk);
    total++;
    if (idx != 17) begin bad++; $display("FAIL stall_accepted got=%0d want=17", idx); end
    total++;
    if (mgr_ds_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", mgr_ds_ready); end
    total++;
    if (sb_ds_valid !== 1'b1 || sb_ds_data !== 32'h100 || sb_ds_cntl !== SOP) begin
      bad++; $display("FAIL stall_head got=%b/%b/%h want=1/01/00000100", sb_ds_valid, sb_ds_cntl, sb_ds_data);
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL stall_stable changes=%0d want=0", unstable); end
    total++;
    if (pkts_buffered !== 5'd4) begin bad++; $display("FAIL stall_pkts got=%0d want=4", pkts_buffered); end
    @(posedge clk) #1;
    mgr_ds_valid = 1'b0; sb_ds_ready = 1'b1;
    for (int i = idx; i < 20; i++) send_word(ec[i], ed[i]);
    wait_rx(20);
    for (int i = 0; i < 20; i++) chk_word(i, ec[i], ed[i]);
    total++;
    if (pkts_buffered !== 5'd0) begin bad++; $display("FAIL stall_pkts_end got=%0d want=0", pkts_buffered); end
  endtask

  task automatic test_too_long;
    rx_q.delete(); sb_ds_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_word((i == 0) ? SOP : (i == 19) ? EOP : MOP, 32'h200 + i);
      if (i == 14) begin
        total++;
        if (err_pkt_too_long !== 1'b0) begin bad++; $display("FAIL long_early got=%b want=0", err_pkt_too_long); end
      end
      if (i == 15) begin
        total++;
        if (err_pkt_too_long !== 1'b1) begin bad++; $display("FAIL long_flag got=%b want=1", err_pkt_too_long); end
      end
    end
    wait_rx(16);
    for (int i = 0; i < 16; i++) chk_word(i, (i == 0) ? SOP : (i == 15) ? EOP : MOP, 32'h200 + i);
    total++;
    if (err_pkt_too_long !== 1'b1 || err_protocol !== 1'b0 || pkts_buffered !== 5'd0) begin
      bad++; $display("FAIL long_end el=%b ep=%b p=%0d want 1/0/0", err_pkt_too_long, err_protocol, pkts_buffered);
    end
  endtask

  task automatic test_protocol;
    rx_q.delete();
    send_word(MOP, 32'h301);
    total++;
    if (err_protocol !== 1'b1 || pkts_buffered !== 5'd0) begin
      bad++; $display("FAIL proto_mop ep=%b p=%0d want 1/0", err_protocol, pkts_buffered);
    end
    send_word(SOP, 32'h302); send_word(SOP, 32'h303); send_word(EOP, 32'h304);
    wait_rx(3);
    chk_word(0, SOP, 32'h302);
    chk_word(1, MOP, 32'h303);
    chk_word(2, EOP, 32'h304);
  endtask

  task automatic test_reset_mid;
    rx_q.delete(); sb_ds_ready = 1'b1;
    send_word(SOP, 32'h401); send_word(MOP, 32'h402); send_word(EOP, 32'h403);
    send_word(SOP, 32'h404);
    @(negedge clk);
    total++;
    if (sb_ds_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", sb_ds_valid); end
    rst = 1'b1;
    #1;
    total++;
    if (sb_ds_valid !== 1'b0 || pkts_buffered !== 5'd0 || err_protocol !== 1'b0) begin
      bad++; $display("FAIL rmid_reset v=%b p=%0d ep=%b want 0/0/0", sb_ds_valid, pkts_buffered, err_protocol);
    end
    @(posedge clk) #1;
    rst = 1'b0;
    rx_q.delete();
    send_word(SOP, 32'h501); send_word(EOP, 32'h502);
    wait_rx(2);
    chk_word(0, SOP, 32'h501);
    chk_word(1, EOP, 32'h502);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full_stall();
    test_too_long();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
